// File: rtl/bu_sched_pkg.sv
// Shared types and width helpers for the NTT/INTT butterfly scheduler.
package bu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } mode_e;

  function automatic int stage_width(input int log_n);
    return $clog2(log_n + 1);
  endfunction

  function automatic int tw_width(input int log_n);
    return (log_n > 1) ? log_n - 1 : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bu_scheduler_if.sv
// Operand-fetch and writeback bus between the scheduler and the coefficient RAM.
interface bu_scheduler_if import bu_sched_pkg::*; #(
  parameter int LOG_N = 8
);

  localparam int TW_W = tw_width(LOG_N);

  logic             rd_en_o;
  logic [LOG_N-1:0] rd_addr0_o;
  logic [LOG_N-1:0] rd_addr1_o;
  logic [TW_W-1:0]  tw_idx_o;
  logic             wr_en_o;
  logic [LOG_N-1:0] wr_addr0_o;
  logic [LOG_N-1:0] wr_addr1_o;

  modport master (
    output rd_en_o, rd_addr0_o, rd_addr1_o, tw_idx_o,
    output wr_en_o, wr_addr0_o, wr_addr1_o
  );

  modport slave (
    input rd_en_o, rd_addr0_o, rd_addr1_o, tw_idx_o,
    input wr_en_o, wr_addr0_o, wr_addr1_o
  );

endinterface

// File: rtl/bu_wb_pipe.sv
// Delay line that replays issued butterfly addresses as writebacks DEPTH cycles later.
module bu_wb_pipe import bu_sched_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          en_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  output logic          en_o,
  output logic [AW-1:0] addr0_o,
  output logic [AW-1:0] addr1_o
);

  logic [DEPTH-1:0] en_q, en_d;
  logic [AW-1:0]    addr0_q [DEPTH];
  logic [AW-1:0]    addr0_d [DEPTH];
  logic [AW-1:0]    addr1_q [DEPTH];
  logic [AW-1:0]    addr1_d [DEPTH];

  always_comb begin
    en_d       = '0;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    en_d[0]    = en_i;
    addr0_d[0] = addr0_i;
    addr1_d[0] = addr1_i;
    for (int i = 1; i < DEPTH; i++) begin
      en_d[i]    = en_q[i-1];
      addr0_d[i] = addr0_q[i-1];
      addr1_d[i] = addr1_q[i-1];
    end
  end

  // Clearing the valid bits on reset drops writebacks for butterflies already in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      en_q    <= '0;
      addr0_q <= '{default: '0};
      addr1_q <= '{default: '0};
    end else begin
      en_q    <= en_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
    end
  end

  assign en_o    = en_q[DEPTH-1];
  assign addr0_o = addr0_q[DEPTH-1];
  assign addr1_o = addr1_q[DEPTH-1];

endmodule

// File: rtl/bu_scheduler.sv
// Sequences the N/2 butterflies of each NTT/INTT stage, inserting a BU_LAT drain
// between stages so no operand is read before its previous-stage result lands.
module bu_scheduler import bu_sched_pkg::*; #(
  parameter int LOG_N  = 8,
  parameter int BU_LAT = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic                          hold_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          mode_o,
  output logic [stage_width(LOG_N)-1:0] stage_o,
  bu_scheduler_if.master                bus
);

  localparam int SW   = stage_width(LOG_N);
  localparam int TW_W = tw_width(LOG_N);
  localparam int K_W  = tw_width(LOG_N);
  localparam int D_W  = cnt_width(BU_LAT);

  localparam logic [SW-1:0]  LAST_STAGE = SW'(LOG_N - 1);
  localparam logic [K_W-1:0] K_LAST     = K_W'((1 << (LOG_N - 1)) - 1);
  localparam logic [D_W-1:0] D_LAST     = D_W'(BU_LAT - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [D_W-1:0]   drain_q, drain_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_addr0_q, rd_addr0_d;
  logic [LOG_N-1:0] rd_addr1_q, rd_addr1_d;
  logic [TW_W-1:0]  tw_q, tw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LOG_N-1:0] k_ext, half, pos, addr0_c, addr1_c;
  logic [TW_W-1:0]  tw_c;
  logic             stage_last;
  logic [SW-1:0]    stage_next;

  logic             wr_en;
  logic [LOG_N-1:0] wr_addr0, wr_addr1;

  always_comb begin
    k_ext   = LOG_N'(k_q);
    half    = LOG_N'(1) << stage_q;
    pos     = k_ext & (half - LOG_N'(1));
    addr0_c = ((k_ext >> stage_q) << (stage_q + SW'(1))) + pos;
    addr1_c = addr0_c + half;
    tw_c    = TW_W'(pos) << (LAST_STAGE - stage_q);
  end

  // INTT walks the stages from the widest span down, NTT the other way.
  always_comb begin
    stage_last = (mode_q == MODE_INTT) ? (stage_q == '0) : (stage_q == LAST_STAGE);
    stage_next = (mode_q == MODE_INTT) ? stage_q - SW'(1) : stage_q + SW'(1);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    stage_d    = stage_q;
    k_d        = k_q;
    drain_d    = drain_q;
    rd_en_d    = 1'b0;
    rd_addr0_d = rd_addr0_q;
    rd_addr1_d = rd_addr1_q;
    tw_d       = tw_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE;
          mode_d  = mode_e'(mode_i);
          stage_d = mode_i ? LAST_STAGE : '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        busy_d = 1'b1;
        if (!hold_i) begin
          rd_en_d    = 1'b1;
          rd_addr0_d = addr0_c;
          rd_addr1_d = addr1_c;
          tw_d       = tw_c;
          if (k_q == K_LAST) begin
            k_d     = '0;
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      DRAIN: begin
        busy_d = 1'b1;
        if (drain_q == D_LAST) begin
          if (stage_last) begin
            state_d = DONE;
          end else begin
            stage_d = stage_next;
            state_d = ISSUE;
          end
        end else begin
          drain_d = drain_q + D_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        stage_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      mode_q     <= MODE_NTT;
      stage_q    <= '0;
      k_q        <= '0;
      drain_q    <= '0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      tw_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      stage_q    <= stage_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      rd_en_q    <= rd_en_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      tw_q       <= tw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  bu_wb_pipe #(
    .DEPTH (BU_LAT),
    .AW    (LOG_N)
  ) u_wb_pipe (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (rd_en_q),
    .addr0_i  (rd_addr0_q),
    .addr1_i  (rd_addr1_q),
    .en_o     (wr_en),
    .addr0_o  (wr_addr0),
    .addr1_o  (wr_addr1)
  );

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mode_o         = mode_q;
  assign stage_o        = stage_q;
  assign bus.rd_en_o    = rd_en_q;
  assign bus.rd_addr0_o = rd_addr0_q;
  assign bus.rd_addr1_o = rd_addr1_q;
  assign bus.tw_idx_o   = tw_q;
  assign bus.wr_en_o    = wr_en;
  assign bus.wr_addr0_o = wr_addr0;
  assign bus.wr_addr1_o = wr_addr1;

endmodule

// File: tb/tb_bu_scheduler.sv
// Directed vector table for a 4-point scheduler plus corner-case sequences and a
// randomly held 256-point run checked against the butterfly address formula.
module tb_bu_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, mode_a, hold_a, busy_a, done_a, mode_oa;
  logic [1:0] stage_a;
  logic       start_b, mode_b, hold_b, busy_b, done_b, mode_ob;
  logic [3:0] stage_b;

  bu_scheduler_if #(.LOG_N(2)) bus_a ();
  bu_scheduler_if #(.LOG_N(8)) bus_b ();

  bu_scheduler #(.LOG_N(2), .BU_LAT(2)) dut_a (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_a), .mode_i(mode_a), .hold_i(hold_a),
    .busy_o(busy_a), .done_o(done_a), .mode_o(mode_oa), .stage_o(stage_a), .bus(bus_a)
  );

  bu_scheduler #(.LOG_N(8), .BU_LAT(3)) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_b), .mode_i(mode_b), .hold_i(hold_b),
    .busy_o(busy_b), .done_o(done_b), .mode_o(mode_ob), .stage_o(stage_b), .bus(bus_b)
  );

  typedef struct {
    int start; int mode; int hold;
    int rd_en; int chk_ra; int ra0; int ra1; int tw;
    int wr_en; int wa0; int wa1;
    int busy; int done; int mode_o; int stage;
  } vec_t;

  typedef struct { int t; int a0; int a1; } rdrec_t;

  vec_t   vecs[$];
  rdrec_t rq[$];
  bit     pending [256];
  int     pass_cnt = 0;
  int     check_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(int st, int md, int hd, int re, int ck, int a0, int a1, int tw,
                              int we, int w0, int w1, int bz, int dn, int mo, int sg);
    vec_t v;
    v = '{st, md, hd, re, ck, a0, a1, tw, we, w0, w1, bz, dn, mo, sg};
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    start_a = v.start[0];
    mode_a  = v.mode[0];
    hold_a  = v.hold[0];
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("row%0d rd_en", idx), bus_a.rd_en_o, v.rd_en);
    check($sformatf("row%0d wr_en", idx), bus_a.wr_en_o, v.wr_en);
    check($sformatf("row%0d busy", idx), busy_a, v.busy);
    check($sformatf("row%0d done", idx), done_a, v.done);
    check($sformatf("row%0d mode_o", idx), mode_oa, v.mode_o);
    check($sformatf("row%0d stage", idx), stage_a, v.stage);
    if (v.chk_ra != 0) begin
      check($sformatf("row%0d rd_addr0", idx), bus_a.rd_addr0_o, v.ra0);
      check($sformatf("row%0d rd_addr1", idx), bus_a.rd_addr1_o, v.ra1);
      check($sformatf("row%0d tw_idx", idx), bus_a.tw_idx_o, v.tw);
    end
    if (v.wr_en != 0) begin
      check($sformatf("row%0d wr_addr0", idx), bus_a.wr_addr0_o, v.wa0);
      check($sformatf("row%0d wr_addr1", idx), bus_a.wr_addr1_o, v.wa1);
    end
  endtask

  initial begin
    int n, wr_seen, rd_seen, done_cnt, done_edge, busy_any;
    int s_m, k_m, cyc, issues, done_seen, e0, e1, etw, half, pos;
    bit hold_now;
    rdrec_t r;

    // Row k holds inputs driven before edge k and outputs expected just after it.
    //             st md hd  re ck a0 a1 tw  we w0 w1  bz dn mo sg
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 2, 3, 0,  0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 1,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 2, 3,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  1, 1, 0, 2, 0,  0, 0, 0,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  1, 1, 1, 3, 1,  0, 0, 0,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 2,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 3,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
    // INTT: widest-span stage first, mode_o held high
    vecs.push_back(mk(1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,  1, 1, 0, 2, 0,  0, 0, 0,  1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,  1, 1, 1, 3, 1,  0, 0, 0,  1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 2,  1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 3,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 0, 1, 0,  0, 0, 0,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 2, 3, 0,  0, 0, 0,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 1,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 2, 3,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0));
    // NTT with three held cycles after the first issue, then a hold ignored in DRAIN
    vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,  0, 1, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,  0, 1, 0, 1, 0,  1, 0, 1,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,  0, 1, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 1, 2, 3, 0,  0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 2, 3,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  1, 1, 0, 2, 0,  0, 0, 0,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  1, 1, 1, 3, 1,  0, 0, 0,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 2,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 3,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0));

    rst_n = 1'b0;
    start_a = 1'b0; mode_a = 1'b0; hold_a = 1'b0;
    start_b = 1'b0; mode_b = 1'b0; hold_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rd_en", bus_a.rd_en_o, 0);
    check("reset wr_en", bus_a.wr_en_o, 0);
    check("reset busy", busy_a, 0);
    check("reset done", done_a, 0);
    check("reset B busy", busy_b, 0);
    rst_n = 1'b1;

    $display("[TB] directed vector table, %0d rows", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(vecs[i], i);
    end
    start_a = 1'b0; hold_a = 1'b0;

    $display("[TB] mid-transform reset");
    mode_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; mode_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset busy", busy_a, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("post-reset rd_en", bus_a.rd_en_o, 0);
    check("post-reset wr_en", bus_a.wr_en_o, 0);
    check("post-reset busy", busy_a, 0);
    check("post-reset done", done_a, 0);
    check("post-reset mode_o", mode_oa, 0);
    check("post-reset stage", stage_a, 0);
    check("post-reset rd_addr0", bus_a.rd_addr0_o, 0);
    check("post-reset rd_addr1", bus_a.rd_addr1_o, 0);
    check("post-reset tw_idx", bus_a.tw_idx_o, 0);
    check("post-reset wr_addr0", bus_a.wr_addr0_o, 0);
    check("post-reset wr_addr1", bus_a.wr_addr1_o, 0);
    rst_n = 1'b1;
    wr_seen = 0; rd_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      wr_seen += int'(bus_a.wr_en_o);
      rd_seen += int'(bus_a.rd_en_o);
    end
    check("stale writes after reset", wr_seen, 0);
    check("reads after reset", rd_seen, 0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("restart done latency", n, 9);
    @(posedge clk); #1;

    $display("[TB] start pulses while busy");
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    done_cnt = 0; done_edge = -1; busy_any = 0;
    for (int e = 1; e <= 20; e++) begin
      start_a = (e == 3 || e == 7 || e == 9);
      @(posedge clk); #1;
      if (done_a) begin
        done_cnt++;
        done_edge = e;
      end
      if (e >= 10) busy_any |= int'(busy_a);
    end
    start_a = 1'b0;
    check("busy start done count", done_cnt, 1);
    check("busy start done edge", done_edge, 9);
    check("busy start restarted", busy_any, 0);

    $display("[TB] 256-point NTT with random holds");
    s_m = 0; k_m = 0; cyc = 0; issues = 0; done_seen = 0;
    mode_b = 1'b0; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    while (!done_seen && cyc < 4000) begin
      hold_now = ($urandom_range(0, 3) == 0);
      hold_b = hold_now;
      @(posedge clk); #1;
      cyc++;
      if (hold_now) check("B held rd_en", bus_b.rd_en_o, 0);
      if (bus_b.rd_en_o) begin
        half = 1 << s_m;
        pos  = k_m & (half - 1);
        e0   = ((k_m >> s_m) << (s_m + 1)) + pos;
        e1   = e0 + half;
        etw  = pos << (7 - s_m);
        check($sformatf("B s%0d k%0d addr0", s_m, k_m), bus_b.rd_addr0_o, e0);
        check($sformatf("B s%0d k%0d addr1", s_m, k_m), bus_b.rd_addr1_o, e1);
        check($sformatf("B s%0d k%0d tw", s_m, k_m), bus_b.tw_idx_o, etw);
        check($sformatf("B s%0d k%0d stage", s_m, k_m), stage_b, s_m);
        check($sformatf("B s%0d k%0d RAW hazard", s_m, k_m),
              int'(pending[bus_b.rd_addr0_o] | pending[bus_b.rd_addr1_o]), 0);
        issues++;
        k_m++;
        if (k_m == 128) begin
          k_m = 0;
          s_m++;
        end
      end
      if (bus_b.wr_en_o) begin
        if (rq.size() == 0) begin
          check("B wr without pending rd", rq.size(), 1);
        end else begin
          r = rq.pop_front();
          check("B wr latency", cyc - r.t, 3);
          check("B wr addr0", bus_b.wr_addr0_o, r.a0);
          check("B wr addr1", bus_b.wr_addr1_o, r.a1);
          pending[r.a0] = 1'b0;
          pending[r.a1] = 1'b0;
        end
      end
      if (bus_b.rd_en_o) begin
        pending[bus_b.rd_addr0_o] = 1'b1;
        pending[bus_b.rd_addr1_o] = 1'b1;
        rq.push_back('{cyc, int'(bus_b.rd_addr0_o), int'(bus_b.rd_addr1_o)});
      end
      if (done_b) done_seen = 1;
    end
    hold_b = 1'b0;
    check("B done reached", done_seen, 1);
    check("B issue count", issues, 1024);
    check("B writes outstanding", rq.size(), 0);
    check("B busy at done", busy_b, 0);
    check("B mode_o", mode_ob, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/bu_scheduler.md
BU_SCHEDULER -- requirements
Module: bu_scheduler

Interface
REQ-001 SHALL have parameter LOG_N, default 8: log2 of transform length N; legal range 1..12.
REQ-002 SHALL have parameter BU_LAT, default 2: butterfly read-to-writeback latency in cycles; legal range 1..8.
REQ-003 SHALL have the port clk_i, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have the port reset_ni, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have the port start_i, input, 1 bit: request a full transform; sampled only in IDLE.
REQ-006 SHALL have the port mode_i, input, 1 bit: 0 = NTT, 1 = INTT; captured with start_i.
REQ-007 SHALL have the port hold_i, input, 1 bit: freezes issue; the writeback pipe keeps advancing.
REQ-008 SHALL have the port busy_o, output, 1 bit: high from the cycle after accepted start until done_o.
REQ-009 SHALL have the port done_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have the port mode_o, output, 1 bit: captured mode, steering NTT_BU vs INTT_BU result.
REQ-011 SHALL have the ports rd_en_o (1 bit), rd_addr0_o (LOG_N bits), rd_addr1_o (LOG_N bits) and tw_idx_o (LOG_N-1 bits, min 1), all outputs: butterfly operand fetch.
REQ-012 SHALL have the ports wr_en_o (1 bit), wr_addr0_o (LOG_N bits), wr_addr1_o (LOG_N bits), all outputs: result writeback.
REQ-013 SHALL have the port stage_o, output, ceil(log2(LOG_N+1)) bits: current stage index.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE->ISSUE SHALL occur when start_i=1; start_i SHALL be ignored in every other state.
REQ-016 Butterfly counter k SHALL count 0..N/2-1 per stage, one issue per cycle while hold_i=0.
REQ-017 For stage s: half=1<<s, pos=k&(half-1), addr0=((k>>s)<<(s+1))+pos, addr1=addr0+half, tw_idx=pos<<(LOG_N-1-s).
REQ-018 NTT mode SHALL run stages s=0..LOG_N-1; INTT mode SHALL run s=LOG_N-1 down to 0.
REQ-019 All outputs SHALL be registered; the first rd_en_o SHALL appear one cycle after start_i is accepted.
REQ-020 wr_en_o/wr_addr*_o SHALL equal rd_en_o/rd_addr*_o delayed exactly BU_LAT cycles.
REQ-021 After the last issue of a stage, the FSM SHALL enter DRAIN for BU_LAT cycles with rd_en_o=0 (RAW hazard guard), then start the next stage in ISSUE or, after the final stage, go to DONE.
REQ-022 DONE SHALL last one cycle with done_o=1 and busy_o=0, then return to IDLE; this cycle is the one after the final wr_en_o.
REQ-023 With hold_i=0, done_o SHALL occur LOG_N*(N/2+BU_LAT)+1 cycles after the start_i edge.
REQ-024 hold_i=1 in ISSUE SHALL force rd_en_o=0 and freeze k, stage and addresses; hold_i SHALL be ignored in DRAIN (the count continues).
REQ-025 Address arithmetic SHALL be LOG_N bits with no overflow (addr1 max N-1).

Reset
REQ-026 reset_ni=0 at a clock edge SHALL force IDLE, clear counters and the writeback pipe, and set every output to 0, including mid-transform.
REQ-027 No write SHALL be emitted after reset for butterflies issued before reset.

Structure
REQ-028 Package bu_sched_pkg SHALL hold the FSM state enum, the mode enum (MODE_NTT=0, MODE_INTT=1) and the width helper functions.
REQ-029 The writeback delay line SHALL be sub-module bu_wb_pipe (parameter DEPTH=BU_LAT; carries en, addr0, addr1).

Verification
REQ-030 The bench SHALL cover LOG_N=2, BU_LAT=2, NTT start at cycle 0 -> rd at cycles 1..2 = (0,1,tw0),(2,3,tw0), rd at cycles 5..6 = (0,2,tw0),(1,3,tw1), wr at cycles 3,4,7,8, done_o at cycle 9.
REQ-031 The bench SHALL cover the same configuration in INTT -> stage-1 pairs (0,2,0),(1,3,1) first, then (0,1,0),(2,3,0); mode_o=1 throughout; done at cycle 9.
REQ-032 The bench SHALL cover hold_i=1 for 3 cycles after the first issue -> addresses frozen, rd_en_o low 3 cycles, done_o at cycle 12.
REQ-033 The bench SHALL cover reset_ni=0 at cycle 4 -> next cycle all outputs 0, no later wr_en_o, start accepted normally afterward.
REQ-034 The bench SHALL cover start_i pulsed while busy -> ignored, no second done_o.
REQ-035 The bench SHALL cover LOG_N=8, BU_LAT=3 random holds -> every (addr0,addr1) pair appears once per stage, and no rd of an address occurs within BU_LAT cycles of its pending wr.
